// File: rtl/cocotb_array_pkg.sv
// Shared types for the 3x3 array write/readback scheduler.
package cocotb_array_pkg;

    localparam int ARR_DIM = 3;

    typedef logic [1:0] coord_t;

    typedef enum logic {IDLE, SWEEP} sched_state_t;

    function automatic logic coord_in_range(coord_t row, coord_t col);
        return (row < coord_t'(ARR_DIM)) && (col < coord_t'(ARR_DIM));
    endfunction

endpackage

// File: rtl/cocotb_array_rr_arb.sv
// Three-way round-robin arbiter; the search starts at the priority pointer and wraps.
module cocotb_array_rr_arb
    import cocotb_array_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_valid,
    input  logic       update_en,
    output logic [2:0] grant
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;

    always_comb begin
        grant = 3'b000;
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 0; k < ARR_DIM; k++) begin
            idx = (int'(ptr_q) + k >= ARR_DIM) ? 2'(int'(ptr_q) + k - ARR_DIM)
                                               : 2'(int'(ptr_q) + k);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_en && found) begin
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cocotb_array_sched.sv
// 3x3 cell array with arbitrated single-cell writes and a row-major readback sweep.
module cocotb_array_sched
    import cocotb_array_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [1:0]        req_row [2:0],
    input  logic [1:0]        req_col [2:0],
    input  logic [DATA_W-1:0] req_data [2:0],
    input  logic              sweep_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_row,
    output logic [1:0]        out_col,
    output logic [DATA_W-1:0] out_data,
    output logic              sweep_done,
    output logic              busy,
    output logic              addr_err,
    output logic [DATA_W-1:0] arr_view [2:0][2:0]
);

    sched_state_t      state_q, state_d;
    coord_t            row_q, row_d, col_q, col_d;
    logic [DATA_W-1:0] arr_q [2:0][2:0];
    logic              done_q;
    logic              err_q;

    logic [2:0]        grant;
    logic              arb_en;
    logic              wr_fire;
    coord_t            wr_row, wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              beat;
    logic              last;

    assign arb_en = (state_q == IDLE) && !rst;

    cocotb_array_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .update_en (arb_en),
        .grant     (grant)
    );

    assign req_ready = arb_en ? grant : 3'b000;
    assign wr_fire   = |req_ready;

    always_comb begin
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        for (int i = 0; i < ARR_DIM; i++) begin
            if (req_ready[i]) begin
                wr_row  = req_row[i];
                wr_col  = req_col[i];
                wr_data = req_data[i];
            end
        end
    end

    assign out_valid  = (state_q == SWEEP);
    assign busy       = (state_q == SWEEP);
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign sweep_done = done_q;
    assign addr_err   = err_q;
    assign arr_view   = arr_q;
    assign beat       = out_valid && out_ready;
    assign last       = (row_q == 2'd2) && (col_q == 2'd2);

    always_comb begin
        out_data = '0;
        for (int r = 0; r < ARR_DIM; r++) begin
            for (int c = 0; c < ARR_DIM; c++) begin
                if (row_q == coord_t'(r) && col_q == coord_t'(c)) begin
                    out_data = arr_q[r][c];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (beat) begin
                    if (last) begin
                        state_d = IDLE;
                        row_d   = 2'd0;
                        col_d   = 2'd0;
                    end else if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int r = 0; r < ARR_DIM; r++) begin
                for (int c = 0; c < ARR_DIM; c++) begin
                    arr_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= beat && last;
            // Out-of-range writes still handshake; the data is dropped and the flag latches.
            if (wr_fire && !coord_in_range(wr_row, wr_col)) begin
                err_q <= 1'b1;
            end
            for (int r = 0; r < ARR_DIM; r++) begin
                for (int c = 0; c < ARR_DIM; c++) begin
                    if (wr_fire && wr_row == coord_t'(r) && wr_col == coord_t'(c)) begin
                        arr_q[r][c] <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cocotb_array_sched.sv
// Randomized and directed bench for cocotb_array_sched against a cycle-level reference model.
module tb_cocotb_array_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [1:0] req_row [2:0];
    logic [1:0] req_col [2:0];
    logic [7:0] req_data [2:0];
    logic       sweep_start;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic [7:0] out_data;
    logic       sweep_done;
    logic       busy;
    logic       addr_err;
    logic [7:0] arr_view [2:0][2:0];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cell array, priority pointer, sweep flag and beat index 0..8.
    int m_arr [3][3];
    int m_ptr;
    bit m_sweep;
    int m_k;
    bit m_done;
    bit m_err;

    cocotb_array_sched #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_row     (req_row),
        .req_col     (req_col),
        .req_data    (req_data),
        .sweep_start (sweep_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_data    (out_data),
        .sweep_done  (sweep_done),
        .busy        (busy),
        .addr_err    (addr_err),
        .arr_view    (arr_view)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < 3; k++) begin
            if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        foreach (m_arr[r, c]) m_arr[r][c] = 0;
        m_ptr   = 0;
        m_sweep = 0;
        m_k     = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    // Compare outputs of the current cycle, advance the model, move to the next negedge.
    task automatic step();
        int g;
        logic [2:0] er;
        g  = pick();
        er = (!rst && !m_sweep && g >= 0) ? 3'(1 << g) : 3'b000;
        check("req_ready", 32'(req_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_sweep));
        check("busy", 32'(busy), 32'(m_sweep));
        check("sweep_done", 32'(sweep_done), 32'(m_done));
        check("addr_err", 32'(addr_err), 32'(m_err));
        if (m_sweep) begin
            check("out_row", 32'(out_row), 32'(m_k / 3));
            check("out_col", 32'(out_col), 32'(m_k % 3));
            check("out_data", 32'(out_data), 32'(m_arr[m_k / 3][m_k % 3]));
        end
        foreach (m_arr[r, c]) check($sformatf("arr[%0d][%0d]", r, c), 32'(arr_view[r][c]),
                                    32'(m_arr[r][c]));
        if (rst) begin
            model_reset();
        end else if (!m_sweep) begin
            m_done = 0;
            if (g >= 0) begin
                if (req_row[g] < 3 && req_col[g] < 3) m_arr[req_row[g]][req_col[g]] = req_data[g];
                else m_err = 1;
                m_ptr = (g + 1) % 3;
            end
            if (sweep_start) begin
                m_sweep = 1;
                m_k     = 0;
            end
        end else begin
            m_done = 0;
            if (out_ready) begin
                if (m_k == 8) begin
                    m_sweep = 0;
                    m_k     = 0;
                    m_done  = 1;
                end else begin
                    m_k++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc();
        #1;
        step();
    endtask

    task automatic idle_inputs();
        req_valid   = 3'b000;
        sweep_start = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_row[i]  = 2'd0;
            req_col[i]  = 2'd0;
            req_data[i] = 8'd0;
        end
    endtask

    initial begin
        logic [2:0] seq [6];
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        model_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        cyc();
        cyc();

        // Reset release with all three requesters active.
        rst       = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_row[i]  = 2'(i);
            req_col[i]  = 2'(i);
            req_data[i] = 8'(16 * (i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_seq", 32'(req_ready), 32'(seq[i]));
            step();
        end
        idle_inputs();
        #1;
        check("rr_cell00", 32'(arr_view[0][0]), 32'h10);
        check("rr_cell11", 32'(arr_view[1][1]), 32'h20);
        check("rr_cell22", 32'(arr_view[2][2]), 32'h30);
        step();

        // Fill every cell, then a full-speed sweep.
        req_valid = 3'b001;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                req_row[0]  = 2'(r);
                req_col[0]  = 2'(c);
                req_data[0] = 8'(8'h11 * (3 * r + c));
                cyc();
            end
        end
        idle_inputs();
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            check("beat_data", 32'(out_data), 32'(8'h11 * k));
            step();
        end
        #1;
        check("fill_done", 32'(sweep_done), 32'd1);
        step();
        cyc();

        // Backpressure: alternating out_ready.
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 2 == 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        cyc();

        // Write held off for the whole sweep, then committed.
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        req_valid   = 3'b010;
        req_row[1]  = 2'd1;
        req_col[1]  = 2'd2;
        req_data[1] = 8'h5A;
        for (int i = 0; i < 10; i++) cyc();
        idle_inputs();
        #1;
        check("blocked_commit", 32'(arr_view[1][2]), 32'h5A);
        step();

        // Write granted in the same cycle as sweep_start.
        req_valid   = 3'b001;
        req_row[0]  = 2'd0;
        req_col[0]  = 2'd0;
        req_data[0] = 8'hAB;
        sweep_start = 1'b1;
        cyc();
        idle_inputs();
        #1;
        check("same_cycle_first", 32'(out_data), 32'hAB);
        step();
        for (int i = 0; i < 10; i++) cyc();

        // Out-of-range write.
        req_valid   = 3'b001;
        req_row[0]  = 2'd3;
        req_col[0]  = 2'd1;
        req_data[0] = 8'hFF;
        #1;
        check("oor_ready", 32'(req_ready), 32'b001);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("oor_err_sticky", 32'(addr_err), 32'd1);
            step();
        end

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        cyc();
        sweep_start = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        step();
        cyc();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            req_valid   = 3'($urandom);
            sweep_start = ($urandom_range(0, 9) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 3; i++) begin
                req_row[i]  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                req_col[i]  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                req_data[i] = 8'($urandom);
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cocotb_array_sched.md
# cocotb_array_sched

Write and readback scheduler for a shared 3x3 array of data cells, the same array shape the multi-dimensional passthrough datapath carries. Three requesters write single cells through valid/ready ports and a round-robin arbiter grants at most one write per cycle. A sweep FSM streams all nine cells out in row-major order on request. The full array is also exported as an unpacked 2D view so it can drive the passthrough datapath's unpacked-unpacked inputs directly.

## Interface
Parameters:
- DATA_W, default 8, width of one cell.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [2:0]  one write request per requester.
- req_ready  out  [2:0]  grant; at most one bit high.
- req_row  in  logic [1:0] req_row[2:0]  target row per requester.
- req_col  in  logic [1:0] req_col[2:0]  target column per requester.
- req_data  in  logic [DATA_W-1:0] req_data[2:0]  write data per requester.
- sweep_start  in  1  single-cycle request to stream the array.
- out_valid  out  1  sweep beat valid.
- out_ready  in  1  sweep beat accept.
- out_row, out_col  out  2 each  coordinate of the current beat.
- out_data  out  DATA_W  cell value of the current beat.
- sweep_done  out  1  one-cycle pulse after the last beat.
- busy  out  1  high while in SWEEP.
- addr_err  out  1  sticky flag; set on any accepted write with row==3 or col==3.
- arr_view  out  logic [DATA_W-1:0] arr_view[2:0][2:0]  registered array contents.

## Operation
- FSM states: IDLE and SWEEP.
- IDLE: arbiter active. req_ready[i] is combinational from req_valid and the priority pointer. Requesters must not make valid depend on ready.
- Round robin: the pointer resets to 0. The search starts at the pointer and wraps i = ptr, ptr+1, ptr+2 mod 3. After a grant to i, the pointer becomes (i+1) mod 3. With no grant, the pointer holds.
- Handshake req_valid[i] && req_ready[i] writes req_data[i] to cell [row][col] at the next edge.
- Out-of-range coordinate: the handshake completes and the data is dropped. addr_err sets and stays set until rst.
- IDLE with sweep_start: go to SWEEP. Any write granted in the same cycle still commits and is visible to the sweep.
- SWEEP: req_ready is forced to 0. out_valid = 1. out_row/out_col come from counters starting at (0,0). out_data = arr[out_row][out_col].
- Beat order is row-major: (0,0),(0,1),(0,2),(1,0) … (2,2).
- Counters advance only on out_valid && out_ready. out_* values are held while stalled.
- A transfer at (2,2) moves the FSM to IDLE and resets the counters to (0,0). sweep_done is high for exactly the next cycle.
- sweep_start during SWEEP is ignored; it is not queued.
- Reset values: arr_view all 0, pointer 0, state IDLE, out_valid 0, busy 0, sweep_done 0, addr_err 0, counters (0,0). req_ready is forced to 0 while rst is high.
- rst mid-sweep: the sweep aborts. The next cycle is IDLE with no sweep_done.

## Timing
- Write: handshake in cycle N; arr_view shows the new value in cycle N+1.
- Sweep: sweep_start in cycle N gives out_valid from N+1. With out_ready held high, the beats occupy N+1..N+9, sweep_done is high in N+10, and busy is high in N+1..N+9.
- Each out_ready low cycle during a sweep delays completion by one cycle.
- Arbitration fairness: with all three valids held high continuously, grants rotate 0,1,2,0,…, one per cycle.

## Structure
- cocotb_array_pkg gains:
  - localparam ARR_DIM = 3;
  - typedef coord_t (logic [1:0]);
  - typedef enum sched_state_t {IDLE, SWEEP}.
- Sub-module cocotb_array_rr_arb holds the 3-way round-robin arbiter: req_valid in, one-hot grant out, pointer register inside, and an update-enable input that is low in SWEEP.
- Top level holds the storage, the FSM, the sweep counters and the error flag.

## Test plan
- Reset then all valid: release rst with req_valid=3'b111 held for 6 cycles, data 0x10/0x20/0x30 to cells (0,0)/(1,1)/(2,2) -> req_ready sequence 001,010,100,001,010,100; arr_view[0][0]=0x10, [1][1]=0x20, [2][2]=0x30.
- Fill and sweep: write value 0x11*(3r+c) to every cell, then pulse sweep_start with out_ready=1 -> nine beats 0x00,0x11,…,0x88 in row-major order; busy for 9 cycles; sweep_done is one pulse in the 10th cycle.
- Backpressure: toggle out_ready 1,0,1,0 during a sweep -> no beat lost or duplicated; out_* stable while stalled; completion is delayed by the number of stall cycles.
- Write blocked during sweep: req_valid[1]=1 throughout the sweep -> req_ready=0 until the cycle after the last beat; the write then commits and arr_view updates one cycle later.
- Same-cycle start and write: sweep_start together with a granted write 0xAB to (0,0) -> first beat out_data=0xAB.
- Error and reset: write to (3,1) -> handshake completes, arr_view unchanged, addr_err=1 and held. Assert rst mid-sweep -> out_valid=0, busy=0, addr_err=0, arr_view all zero, no sweep_done.
